alu_mdu_control: RTL and testbench

Execute-stage control block for the MIPS core that generalises ALU operation decoding and adds an iterative multiply/divide unit (MDU) with architectural HI/LO registers. It decodes `alu_op`/`funct` into the ALU control code. It also sequences multi-cycle MULT/MULTU/DIV/DIVU operations and raises a pipeline stall while an MDU result is pending. It sits between the main decoder and the ALU/writeback mux in EX.

---
 rtl/alu_mdu_control.sv | 181 ++++++++++++++++++
 tb/tb_alu_mdu_control.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_control.sv
// EX-stage ALU control decode plus an iterative multiply/divide unit owning HI/LO.
// Define ALU_MDU_DIV_EN to build the divider; without it DIV/DIVU decode as illegal.
module alu_mdu_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [5:0]       alu_control,
    output logic             mf_sel,
    output logic [WIDTH-1:0] mf_data,
    output logic             mdu_busy,
    output logic             stall,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

`ifdef ALU_MDU_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIX = 2'd3} state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 busy_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic [2*WIDTH-1:0]   p_q;
    logic [WIDTH-1:0]     b_q;
    logic                 neg_q, rneg_q, dz_q, div_q;

    logic                 mdu_fn, is_mf, start_mul, start_div, accept;
    logic                 sgn, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, rem_sh, div_diff;
    logic [2*WIDTH-1:0]   mul_d, div_d, mul_res;
    logic [WIDTH-1:0]     quo, rem, fix_hi, fix_lo;

    always_comb begin
        alu_control = 6'b100000;
        illegal     = 1'b0;
        mdu_fn      = 1'b0;
        is_mf       = 1'b0;
        start_mul   = 1'b0;
        start_div   = 1'b0;
        case (alu_op)
            3'b000: alu_control = 6'b100000;
            3'b001: alu_control = 6'b100010;
            3'b011: alu_control = 6'b100100;
            3'b100: alu_control = 6'b100101;
            3'b101: alu_control = 6'b101010;
            3'b110: alu_control = 6'b100110;
            3'b010: begin
                case (funct)
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b101011, 6'b000000, 6'b000010,
                    6'b000011, 6'b000100, 6'b000110, 6'b000111: alu_control = funct;
                    6'b010000, 6'b010010: begin
                        mdu_fn = 1'b1;
                        is_mf  = 1'b1;
                    end
                    6'b011000, 6'b011001: begin
                        mdu_fn    = 1'b1;
                        start_mul = 1'b1;
                    end
                    6'b011010, 6'b011011: begin
                        if (DivEn) begin
                            mdu_fn    = 1'b1;
                            start_div = 1'b1;
                        end else begin
                            illegal = valid;
                        end
                    end
                    default: illegal = valid;
                endcase
            end
            default: illegal = valid;
        endcase
    end

    assign mf_sel    = valid & is_mf;
    assign mf_data   = funct[1] ? lo_q : hi_q;
    assign stall     = valid & mdu_fn & (state_q != S_IDLE);
    assign accept    = valid & ~stall & (start_mul | start_div);
    assign mdu_busy  = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

    // Odd funct codes (MULTU/DIVU) are unsigned; signed ops iterate on magnitudes.
    assign sgn   = ~funct[0];
    assign a_neg = sgn & rs_val[WIDTH-1];
    assign b_neg = sgn & rt_val[WIDTH-1];
    assign a_mag = a_neg ? -rs_val : rs_val;
    assign b_mag = b_neg ? -rt_val : rt_val;

    // Multiply: upper half accumulates, lower half holds the unconsumed multiplier bits.
    assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? b_q : {WIDTH{1'b0}})};
    assign mul_d   = {mul_sum, p_q[WIDTH-1:1]};

    // Restoring divide: upper half is the partial remainder, quotient bits enter at the bottom.
    assign rem_sh   = p_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = rem_sh - {1'b0, b_q};
    assign div_d    = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

    assign mul_res = neg_q ? -p_q : p_q;
    assign quo     = p_q[WIDTH-1:0];
    assign rem     = p_q[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_hi = mul_res[2*WIDTH-1:WIDTH];
        fix_lo = mul_res[WIDTH-1:0];
        if (div_q) begin
            // On divide-by-zero b_q holds the raw dividend rather than a divisor.
            fix_lo = dz_q ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
            fix_hi = dz_q ? b_q : (rneg_q ? -rem : rem);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        cnt_q  <= CNT_W'(WIDTH);
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        div_q  <= start_div;
                        dz_q   <= start_div & (rt_val == '0);
                        if (start_div) begin
                            state_q <= S_DIV;
                            p_q     <= {{WIDTH{1'b0}}, a_mag};
                            b_q     <= (rt_val == '0) ? rs_val : b_mag;
                        end else begin
                            state_q <= S_MUL;
                            p_q     <= {{WIDTH{1'b0}}, b_mag};
                            b_q     <= a_mag;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    p_q   <= (state_q == S_DIV) ? div_d : mul_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_control.sv
// Bench for alu_mdu_control: directed decode checks plus a HI/LO scoreboard
// popped by a monitor whenever the MDU finishes.
module tb_alu_mdu_control;
    localparam int W = 32;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010, F_MULT = 6'b011000,
                           F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic [2:0]   alu_op = 3'b000;
    logic [5:0]   funct = 6'b000000;
    logic [W-1:0] rs_val = '0, rt_val = '0;
    logic [5:0]   alu_control;
    logic         mf_sel, mdu_busy, stall, illegal;
    logic [W-1:0] mf_data, hi, lo;
    logic [1:0]   dbg_state;

    alu_mdu_control #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .alu_op(alu_op), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .alu_control(alu_control), .mf_sel(mf_sel),
        .mf_data(mf_data), .mdu_busy(mdu_busy), .stall(stall), .illegal(illegal),
        .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each busy->idle transition must match the oldest expected {HI,LO}.
    logic prev_busy = 1'b0;
    int   busy_cycles = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
            busy_cycles = 0;
        end else begin
            if (mdu_busy) begin
                busy_cycles++;
            end else if (prev_busy) begin
                chk("busy_len", 64'(busy_cycles), 64'(W + 1));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h expected none", {hi, lo});
                end else begin
                    chk("hilo", {hi, lo}, exp_q.pop_front());
                end
                busy_cycles = 0;
            end
            prev_busy = mdu_busy;
        end
    end

    task automatic issue(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        valid = 1'b1; alu_op = 3'b010; funct = fn; rs_val = a; rt_val = b;
        @(negedge clk);
        while (stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got stall=1 expected stall=0");
        end
        @(posedge clk);
        #1;
        valid = 1'b0; alu_op = 3'b000; funct = 6'b000000;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (mdu_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (mdu_busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic decode(input logic [2:0] op, input logic [5:0] fn, input logic [5:0] exp_ctl,
                          input logic exp_ill, input string name);
        valid = 1'b1; alu_op = op; funct = fn;
        #1;
        chk({name, "_ctl"}, 64'(alu_control), 64'(exp_ctl));
        chk({name, "_ill"}, 64'(illegal), 64'(exp_ill));
        valid = 1'b0; alu_op = 3'b000; funct = 6'b000000;
        #1;
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_busy", 64'(mdu_busy), 64'h0);
        chk("rst_state", 64'(dbg_state), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_illegal", 64'(illegal), 64'h0);
        chk("rst_mf_sel", 64'(mf_sel), 64'h0);

        // Decode table
        decode(3'b010, 6'b100010, 6'b100010, 1'b0, "sub");
        decode(3'b010, 6'b101011, 6'b101011, 1'b0, "sltu");
        decode(3'b010, 6'b000111, 6'b000111, 1'b0, "srav");
        decode(3'b111, 6'b100010, 6'b100000, 1'b1, "op111");
        decode(3'b101, 6'b000000, 6'b101010, 1'b0, "op_slt");
        decode(3'b110, 6'b111111, 6'b100110, 1'b0, "op_xor");
        decode(3'b010, 6'b111111, 6'b100000, 1'b1, "bad_funct");
        decode(3'b010, F_MFHI, 6'b100000, 1'b0, "mfhi");

        // MULT -3*7, then ADD (no stall) and MFLO (stalls until result lands)
        @(posedge clk); #1;
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
        issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
        valid = 1'b1; alu_op = 3'b000;
        #1;
        chk("add_busy_stall", 64'(stall), 64'h0);
        chk("add_busy_ctl", 64'(alu_control), 64'h20);
        chk("busy_after_accept", 64'(mdu_busy), 64'h1);
        alu_op = 3'b010; funct = F_MFLO;
        #1;
        chk("mflo_stall", 64'(stall), 64'h1);
        chk("lo_held", 64'(lo), 64'h0);
        n = 0;
        @(negedge clk);
        while (stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mflo_stall_released", 64'(stall), 64'h0);
        chk("mflo_sel", 64'(mf_sel), 64'h1);
        chk("mflo_data", 64'(mf_data), 64'hFFFF_FFEB);
        @(posedge clk); #1;
        valid = 1'b0; alu_op = 3'b000; funct = 6'b000000;

        // MULTU 0xFFFFFFFF * 2
        exp_q.push_back({32'h1, 32'hFFFF_FFFE});
        issue(F_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_idle();

`ifndef ALU_MDU_DIV_EN
        // Divider absent: DIV is illegal and never starts
        valid = 1'b1; alu_op = 3'b010; funct = F_DIV; rs_val = 32'd100; rt_val = 32'd7;
        #1;
        chk("nodiv_illegal", 64'(illegal), 64'h1);
        chk("nodiv_stall", 64'(stall), 64'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("nodiv_busy", 64'(mdu_busy), 64'h0);
        chk("nodiv_hilo", {hi, lo}, {32'h1, 32'hFFFF_FFFE});
        valid = 1'b0; alu_op = 3'b000; funct = 6'b000000;
`endif

        // Back-to-back: second op stalls through the first, including its FIX cycle
        exp_q.push_back({32'h0, 32'd6});
        exp_q.push_back({32'h0, 32'd25});
        issue(F_MULT, 32'd2, 32'd3);
        issue(F_MULTU, 32'd5, 32'd5);
        wait_idle();

`ifdef ALU_MDU_DIV_EN
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        exp_q.push_back({32'd2, 32'd14});
        issue(F_DIVU, 32'd100, 32'd7);
        wait_idle();
        exp_q.push_back({32'd5, 32'hFFFF_FFFF});
        issue(F_DIV, 32'd5, 32'd0);
        wait_idle();
        exp_q.push_back({32'h0, 32'h8000_0000});
        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        issue(F_DIV, 32'd1000, 32'd3);
`else
        issue(F_MULT, 32'd1000, 32'd3);
`endif

        // Asynchronous reset mid-operation discards it
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(mdu_busy), 64'h0);
        chk("midrst_hilo", {hi, lo}, 64'h0);
        chk("midrst_state", 64'(dbg_state), 64'h0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        exp_q.push_back({32'h0, 32'd42});
        issue(F_MULT, 32'd6, 32'd7);
        wait_idle();
        repeat (2) @(posedge clk);

        chk("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
